// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path: state encodings,
// opcodes, ALU/mux select codes and the decoded control word.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // aluOp codes consumed by the ALU decoder
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;  // registered ALU result
    localparam logic [1:0] RES_DATA   = 2'b01;  // memory data register
    localparam logic [1:0] RES_ALU    = 2'b10;  // live ALU output

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       retire;
    } ctrl_word_t;

    function automatic logic op_legal(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and the datapath.
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
    logic [6:0]       op;
    logic             zero;
    logic             memReady;
    logic             pcWrite;
    logic             adrSrc;
    logic             memWrite;
    logic             irWrite;
    logic [1:0]       resultSrc;
    logic [1:0]       aluSrcA;
    logic [1:0]       aluSrcB;
    logic [1:0]       aluOp;
    logic             regWrite;
    logic             illegalOp;
    logic             retire;
    logic [CNT_W-1:0] instrCount;

    // controller side
    modport master (
        input  op, zero, memReady,
        output pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
               aluOp, regWrite, illegalOp, retire, instrCount
    );

    // datapath side
    modport slave (
        output op, zero, memReady,
        input  pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
               aluOp, regWrite, illegalOp, retire, instrCount
    );
endinterface

// File: rtl/ctrl_out_deco.sv
// Moore control-word decode: state plus the memReady/zero qualifiers.
module ctrl_out_deco
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic       zero,
    output ctrl_word_t cw
);

    // One control word per state; unlisted fields stay 0
    always_comb begin
        cw = '0;
        unique case (state)
            FETCH: begin
                cw.adr_src    = 1'b0;
                cw.alu_src_a  = SRCA_PC;
                cw.alu_src_b  = SRCB_FOUR;
                cw.alu_op     = ALUOP_ADD;
                cw.result_src = RES_ALU;
                cw.ir_write   = mem_ready;
                cw.pc_write   = mem_ready;
            end
            DECODE: begin
                // precompute branch target while the register file is read
                cw.alu_src_a = SRCA_OLDPC;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALUOP_ADD;
            end
            MEMADR: begin
                cw.alu_src_a = SRCA_RS1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALUOP_ADD;
            end
            MEMREAD: begin
                cw.adr_src    = 1'b1;
                cw.result_src = RES_ALUOUT;
            end
            MEMWB: begin
                cw.result_src = RES_DATA;
                cw.reg_write  = 1'b1;
                cw.retire     = 1'b1;
            end
            MEMWRITE: begin
                // strobe held until the memory accepts it
                cw.adr_src    = 1'b1;
                cw.result_src = RES_ALUOUT;
                cw.mem_write  = 1'b1;
                cw.retire     = mem_ready;
            end
            EXECUTER: begin
                cw.alu_src_a = SRCA_RS1;
                cw.alu_src_b = SRCB_RS2;
                cw.alu_op    = ALUOP_FUNC;
            end
            EXECUTEI: begin
                cw.alu_src_a = SRCA_RS1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALUOP_FUNC;
            end
            ALUWB: begin
                cw.result_src = RES_ALUOUT;
                cw.reg_write  = 1'b1;
                cw.retire     = 1'b1;
            end
            BEQ: begin
                cw.alu_src_a  = SRCA_RS1;
                cw.alu_src_b  = SRCB_RS2;
                cw.alu_op     = ALUOP_SUB;
                cw.result_src = RES_ALUOUT;
                cw.pc_write   = zero;
                cw.retire     = 1'b1;
            end
            JAL: begin
                // PC <- branch target from DECODE; ALU computes old PC + 4 for rd
                cw.alu_src_a  = SRCA_OLDPC;
                cw.alu_src_b  = SRCB_FOUR;
                cw.alu_op     = ALUOP_ADD;
                cw.result_src = RES_ALUOUT;
                cw.pc_write   = 1'b1;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I main controller: state register, next-state logic and
// retired-instruction counter. Control outputs come from ctrl_out_deco.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_word_t       cw, cw_g;
    logic             illegal;

    ctrl_out_deco u_deco (
        .state     (state_q),
        .mem_ready (bus.memReady),
        .zero      (bus.zero),
        .cw        (cw)
    );

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state sequencing; memReady only matters in memory-access states
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:    if (bus.memReady) state_d = DECODE;
            DECODE: begin
                unique case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (bus.op == OP_LW)      state_d = MEMREAD;
                else if (bus.op == OP_SW) state_d = MEMWRITE;
                else                      state_d = FETCH;
            end
            MEMREAD:  if (bus.memReady) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: if (bus.memReady) state_d = FETCH;
            EXECUTER, EXECUTEI, JAL: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    // Retire counter, wraps naturally at 2^CNT_W
    always_comb begin
        cnt_d = cnt_q;
        if (cw.retire) cnt_d = cnt_q + CNT_W'(1);
    end

    // Output gating so everything reads 0 while reset is asserted
    always_comb begin
        cw_g    = rst_n ? cw : '0;
        illegal = rst_n && (state_q == DECODE) && !op_legal(bus.op);
    end

    assign bus.pcWrite    = cw_g.pc_write;
    assign bus.adrSrc     = cw_g.adr_src;
    assign bus.memWrite   = cw_g.mem_write;
    assign bus.irWrite    = cw_g.ir_write;
    assign bus.resultSrc  = cw_g.result_src;
    assign bus.aluSrcA    = cw_g.alu_src_a;
    assign bus.aluSrcB    = cw_g.alu_src_b;
    assign bus.aluOp      = cw_g.alu_op;
    assign bus.regWrite   = cw_g.reg_write;
    assign bus.retire     = cw_g.retire;
    assign bus.illegalOp  = illegal;
    assign bus.instrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control-word checks for each
// instruction class, stalls, illegal op, async reset and 4-bit counter wrap.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(32)) bus ();
    multicycle_ctrl_if #(.CNT_W(4))  bus4 ();

    multicycle_ctrl #(.CNT_W(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    multicycle_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    // narrow instance sees the same instruction stream
    assign bus4.op       = bus.op;
    assign bus4.zero     = bus.zero;
    assign bus4.memReady = bus.memReady;

    // {pcWrite adrSrc memWrite irWrite, resultSrc, aluSrcA, aluSrcB, aluOp, regWrite illegalOp retire}
    localparam logic [14:0] W_ZERO   = 15'b0000_00_00_00_00_000;
    localparam logic [14:0] W_FETCH  = 15'b1001_10_00_10_00_000;
    localparam logic [14:0] W_FETCH0 = 15'b0000_10_00_10_00_000;
    localparam logic [14:0] W_DEC    = 15'b0000_00_01_01_00_000;
    localparam logic [14:0] W_DECILL = 15'b0000_00_01_01_00_010;
    localparam logic [14:0] W_MADR   = 15'b0000_00_10_01_00_000;
    localparam logic [14:0] W_MRD    = 15'b0100_00_00_00_00_000;
    localparam logic [14:0] W_MWB    = 15'b0000_01_00_00_00_101;
    localparam logic [14:0] W_MWR1   = 15'b0110_00_00_00_00_001;
    localparam logic [14:0] W_MWR0   = 15'b0110_00_00_00_00_000;
    localparam logic [14:0] W_EXR    = 15'b0000_00_10_00_10_000;
    localparam logic [14:0] W_EXI    = 15'b0000_00_10_01_10_000;
    localparam logic [14:0] W_AWB    = 15'b0000_00_00_00_00_101;
    localparam logic [14:0] W_BEQ1   = 15'b1000_00_10_00_01_001;
    localparam logic [14:0] W_BEQ0   = 15'b0000_00_10_00_01_001;
    localparam logic [14:0] W_JAL    = 15'b1000_00_01_10_00_000;

    function automatic logic [14:0] cw_obs();
        return {bus.pcWrite, bus.adrSrc, bus.memWrite, bus.irWrite, bus.resultSrc,
                bus.aluSrcA, bus.aluSrcB, bus.aluOp, bus.regWrite, bus.illegalOp,
                bus.retire};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one controller cycle: apply qualifiers, check at negedge, step past posedge
    task automatic cyc(input string tag, input logic mr, input logic z, input logic [14:0] exp);
        bus.memReady = mr;
        bus.zero     = z;
        @(negedge clk);
        chk(tag, 32'(cw_obs()), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.op = 7'b0; bus.zero = 1'b0; bus.memReady = 1'b0;

        // reset state
        #3;
        chk("rst_word", 32'(cw_obs()), 32'(W_ZERO));
        chk("rst_cnt", bus.instrCount, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // lw, 5 cycles
        bus.op = 7'b0000011;
        cyc("lw_fetch", 1, 0, W_FETCH);
        cyc("lw_dec",   1, 0, W_DEC);
        cyc("lw_madr",  1, 0, W_MADR);
        chk("lw_cnt_mid", bus.instrCount, 32'd0);
        cyc("lw_mrd",   1, 0, W_MRD);
        cyc("lw_mwb",   1, 0, W_MWB);
        chk("lw_cnt", bus.instrCount, 32'd1);

        // sw with two wait cycles in MEMWRITE
        bus.op = 7'b0100011;
        cyc("sw_fetch", 1, 0, W_FETCH);
        cyc("sw_dec",   1, 0, W_DEC);
        cyc("sw_madr",  1, 0, W_MADR);
        cyc("sw_wait1", 0, 0, W_MWR0);
        cyc("sw_wait2", 0, 0, W_MWR0);
        cyc("sw_done",  1, 0, W_MWR1);
        chk("sw_cnt", bus.instrCount, 32'd2);

        // beq taken then not taken
        bus.op = 7'b1100011;
        cyc("beq1_fetch", 1, 1, W_FETCH);
        cyc("beq1_dec",   1, 1, W_DEC);
        cyc("beq1_ex",    1, 1, W_BEQ1);
        cyc("beq0_fetch", 1, 0, W_FETCH);
        cyc("beq0_dec",   1, 0, W_DEC);
        cyc("beq0_ex",    1, 0, W_BEQ0);
        chk("beq_cnt", bus.instrCount, 32'd4);

        // R-type with one fetch stall, then jal, then I-type
        bus.op = 7'b0110011;
        cyc("r_stall",  0, 0, W_FETCH0);
        cyc("r_fetch",  1, 0, W_FETCH);
        cyc("r_dec",    0, 0, W_DEC);
        cyc("r_ex",     0, 0, W_EXR);
        cyc("r_wb",     0, 0, W_AWB);
        chk("r_cnt", bus.instrCount, 32'd5);
        bus.op = 7'b1101111;
        cyc("jal_fetch", 1, 0, W_FETCH);
        cyc("jal_dec",   1, 0, W_DEC);
        cyc("jal_ex",    1, 0, W_JAL);
        cyc("jal_wb",    1, 0, W_AWB);
        chk("jal_cnt", bus.instrCount, 32'd6);
        bus.op = 7'b0010011;
        cyc("i_fetch", 1, 0, W_FETCH);
        cyc("i_dec",   1, 0, W_DEC);
        cyc("i_ex",    1, 0, W_EXI);
        cyc("i_wb",    1, 0, W_AWB);
        chk("i_cnt", bus.instrCount, 32'd7);

        // illegal opcode returns to FETCH without retiring
        bus.op = 7'b1111111;
        cyc("ill_fetch", 1, 0, W_FETCH);
        cyc("ill_dec",   1, 0, W_DECILL);
        cyc("ill_back",  0, 0, W_FETCH0);
        chk("ill_cnt", bus.instrCount, 32'd7);
        chk("cnt4_mid", 32'(bus4.instrCount), 32'd7);

        // async reset in the middle of a stalled store
        bus.op = 7'b0100011;
        cyc("rs_fetch", 1, 0, W_FETCH);
        cyc("rs_dec",   1, 0, W_DEC);
        cyc("rs_madr",  1, 0, W_MADR);
        bus.memReady = 1'b0;
        @(negedge clk);
        chk("rs_memw_on", 32'(bus.memWrite), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rs_memw_off", 32'(bus.memWrite), 32'd0);
        chk("rs_word", 32'(cw_obs()), 32'(W_ZERO));
        chk("rs_cnt", bus.instrCount, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 16 beq retires: wide counter reaches 16, 4-bit counter wraps to 0
        bus.op = 7'b1100011;
        cyc("post_rst_fetch", 1, 0, W_FETCH);
        cyc("post_rst_dec",   1, 0, W_DEC);
        cyc("post_rst_beq",   1, 0, W_BEQ0);
        for (int i = 1; i < 16; i++) begin
            cyc("wrap_fetch", 1, 0, W_FETCH);
            cyc("wrap_dec",   1, 0, W_DEC);
            cyc("wrap_beq",   1, 0, W_BEQ0);
            if (i == 14) chk("cnt4_15", 32'(bus4.instrCount), 32'd15);
        end
        chk("cnt32_16", bus.instrCount, 32'd16);
        chk("cnt4_wrap", 32'(bus4.instrCount), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
